// File: rtl/mem_dump_streamer_pkg.sv
// Shared constants and FSM encoding for the memory dump streamer.
// Address width must track the memory's debug ReadAddr port.
package mem_dump_streamer_pkg;

   localparam int MEM_AW    = 6;
   localparam int MEM_WORDS = 1 << MEM_AW;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

endpackage

// File: rtl/mem_dump_streamer.sv
// Walks the memory debug read port over an inclusive (possibly wrapping) word range
// and streams every word as four bytes on a valid/ready byte stream.
module mem_dump_streamer
   import mem_dump_streamer_pkg::*;
#(
   parameter int AW        = MEM_AW,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          Start,
   input  logic [AW-1:0] FirstAddr,
   input  logic [AW-1:0] LastAddr,
   output logic [AW-1:0] ReadAddr,
   input  logic [31:0]   Data,
   output logic [7:0]    TxData,
   output logic          TxValid,
   input  logic          TxReady,
   output logic          Busy,
   output logic          Done,
   output logic [1:0]    DbgState
);

   localparam logic [AW-1:0] ADDR_ONE = AW'(1);

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] last_addr;
   logic [31:0]   shreg;
   logic [1:0]    cnt;
   logic          accept;
   logic          last_byte;
   logic          at_last;

   // Stream handshake: a byte transfers on any posedge where TxValid && TxReady.
   // TxValid and TxData come only from registers, so they hold while stalled and
   // TxValid cannot fall before its byte is accepted.
   assign TxValid   = (state == ST_SEND);
   assign TxData    = MSB_FIRST ? shreg[31:24] : shreg[7:0];
   assign Busy      = (state != ST_IDLE);
   assign Done      = (state == ST_FIN);
   assign DbgState  = state;

   assign accept    = TxValid && TxReady;
   assign last_byte = accept && (cnt == 2'd3);
   assign at_last   = (ReadAddr == last_addr);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (Start) state_nxt = ST_FETCH;
         ST_FETCH: state_nxt = ST_SEND;
         ST_SEND:  if (last_byte) state_nxt = at_last ? ST_FIN : ST_FETCH;
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         ReadAddr  <= '0;
         last_addr <= '0;
         shreg     <= '0;
         cnt       <= 2'd0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  ReadAddr  <= FirstAddr;
                  last_addr <= LastAddr;
               end
            end
            ST_FETCH: begin
               // Snapshot of the word; a same-edge CPU write is not seen here.
               shreg <= Data;
               cnt   <= 2'd0;
            end
            ST_SEND: begin
               if (accept) begin
                  shreg <= MSB_FIRST ? {shreg[23:0], 8'h00} : {8'h00, shreg[31:8]};
                  cnt   <= cnt + 2'd1;
                  if (last_byte && !at_last) ReadAddr <= ReadAddr + ADDR_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
